data_mem_ctrl: RTL and testbench

- Parametrised, synchronous, byte-addressable big-endian data memory for the pipeline MEM stage. It replaces the combinational data RAM.
- Serves one request at a time through valid/ready request and response handshakes, with a configurable number of wait states.
- Supports byte, half-word and word accesses, with sign- or zero-extension on loads.
- Flags misaligned, out-of-range and reserved-size accesses instead of corrupting memory.

---
 rtl/data_mem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressable big-endian data memory with valid/ready
//               request/response handshakes and configurable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rw,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_mem [DEPTH];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_rw;
    logic [1:0]    w_size;
    logic          w_signed;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [1:0]    w_nbytes_m1;
    logic [32:0]   w_last;
    logic          w_err;
    logic [AW-1:0] w_idx0;
    logic [AW-1:0] w_idx1;
    logic [AW-1:0] w_idx2;
    logic [AW-1:0] w_idx3;
    logic [7:0]    w_b0;
    logic [7:0]    w_b1;
    logic [7:0]    w_b2;
    logic [7:0]    w_b3;
    logic [31:0]   w_load;
    logic [31:0]   w_resp_rdata;

    assign w_accept = (r_state == S_IDLE) && i_req_valid && o_req_ready;

    // With no wait states the request enters RESP on its accept edge, so the
    // live inputs feed the datapath; otherwise the latched copy does.
    assign w_rw     = (r_state == S_IDLE) ? i_req_rw     : r_rw;
    assign w_size   = (r_state == S_IDLE) ? i_req_size   : r_size;
    assign w_signed = (r_state == S_IDLE) ? i_req_signed : r_signed;
    assign w_addr   = (r_state == S_IDLE) ? i_req_addr   : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? i_req_wdata  : r_wdata;

    assign w_enter_resp = rst_n &&
        ((w_accept && (WAIT_STATES == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd1)));

    assign w_nbytes_m1 = (w_size == 2'b00) ? 2'd0 :
                         (w_size == 2'b01) ? 2'd1 : 2'd3;

    // 33-bit end address so accesses near 2^32 cannot wrap back into range
    assign w_last = {1'b0, w_addr} + {31'b0, w_nbytes_m1};

    assign w_err = (w_size == 2'b11) ||
                   ((w_size == 2'b01) && w_addr[0]) ||
                   ((w_size == 2'b10) && (w_addr[1:0] != 2'b00)) ||
                   (w_last >= 33'(DEPTH));

    assign w_idx0 = w_addr[AW-1:0];
    assign w_idx1 = w_idx0 + AW'(1);
    assign w_idx2 = w_idx0 + AW'(2);
    assign w_idx3 = w_idx0 + AW'(3);

    assign w_b0 = r_mem[w_idx0];
    assign w_b1 = r_mem[w_idx1];
    assign w_b2 = r_mem[w_idx2];
    assign w_b3 = r_mem[w_idx3];

    always_comb begin
        w_load = '0;
        case (w_size)
            2'b00:   w_load = {{24{w_signed & w_b0[7]}}, w_b0};
            2'b01:   w_load = {{16{w_signed & w_b0[7]}}, w_b0, w_b1};
            2'b10:   w_load = {w_b0, w_b1, w_b2, w_b3};
            default: w_load = '0;
        endcase
    end

    assign w_resp_rdata = (w_err || w_rw) ? 32'd0 : w_load;

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_rw && !w_err) begin
            case (w_size)
                2'b00: begin
                    r_mem[w_idx0] <= w_wdata[7:0];
                end
                2'b01: begin
                    r_mem[w_idx0] <= w_wdata[15:8];
                    r_mem[w_idx1] <= w_wdata[7:0];
                end
                2'b10: begin
                    r_mem[w_idx0] <= w_wdata[31:24];
                    r_mem[w_idx1] <= w_wdata[23:16];
                    r_mem[w_idx2] <= w_wdata[15:8];
                    r_mem[w_idx3] <= w_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_rw         <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            o_req_ready  <= 1'b1;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= 32'd0;
            o_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rw        <= i_req_rw;
                        r_size      <= i_req_size;
                        r_signed    <= i_req_signed;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_cnt       <= 4'(WAIT_STATES);
                        o_req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            r_state      <= S_RESP;
                            o_resp_valid <= 1'b1;
                            o_resp_rdata <= w_resp_rdata;
                            o_resp_err   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state      <= S_RESP;
                        o_resp_valid <= 1'b1;
                        o_resp_rdata <= w_resp_rdata;
                        o_resp_err   <= w_err;
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= S_IDLE;
                        o_req_ready  <= 1'b1;
                        o_resp_valid <= 1'b0;
                        o_resp_rdata <= 32'd0;
                        o_resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_req_ready  <= 1'b1;
                    o_resp_valid <= 1'b0;
                    o_resp_rdata <= 32'd0;
                    o_resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Scoreboard bench for data_mem_ctrl, instances with 0 and 3
//               wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_rw;
    logic [1:0]       req_signed;
    logic [1:0]       resp_ready;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;

    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    wire  [1:0]       req_ready  = {rdy1, rdy0};
    wire  [1:0]       resp_valid = {rv1, rv0};
    wire  [1:0]       resp_err   = {er1, er0};
    wire  [1:0][31:0] resp_rdata = {rd1, rd0};

    data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(rdy0),
        .i_req_rw(req_rw[0]), .i_req_size(req_size[0]), .i_req_signed(req_signed[0]),
        .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
        .o_resp_valid(rv0), .i_resp_ready(resp_ready[0]),
        .o_resp_rdata(rd0), .o_resp_err(er0)
    );

    data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(rdy1),
        .i_req_rw(req_rw[1]), .i_req_size(req_size[1]), .i_req_signed(req_signed[1]),
        .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
        .o_resp_valid(rv1), .i_resp_ready(resp_ready[1]),
        .o_resp_rdata(rd1), .o_resp_err(er1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mm [2][256];
    int         n_pass  = 0;
    int         n_total = 0;

    // Reference behaviour: error rules, big-endian byte order, extension.
    function automatic void model(input int d, input bit rw, input logic [1:0] sz,
                                  input bit sg, input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int n;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
              (longint'(a) + longint'(n) - 1 >= 256);
        rd  = 32'd0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (rw) mm[d][int'(a[7:0]) + i] = 8'(wd >> (8 * (n - 1 - i)));
                else    rd = (rd << 8) | {24'd0, mm[d][int'(a[7:0]) + i]};
            end
            if (!rw && sg && n == 1 && rd[7])  rd = rd | 32'hFFFF_FF00;
            if (!rw && sg && n == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
            if (rw) rd = 32'd0;
        end
    endfunction

    task automatic drive(input int d, input bit rw, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid[d]  = 1'b1;
        req_rw[d]     = rw;
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
    endtask

    task automatic txn(input int d, input bit rw, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got, output logic got_err);
        exp_t e;
        exp_t q;
        int   n;
        int   lat;
        lat = (d == 0) ? 1 : 4;
        model(d, rw, sz, sg, a, wd, e.rdata, e.err);
        sbq.push_back(e);
        n_total++;
        if (req_ready[d] !== 1'b1) $display("FAIL req_ready_before d=%0d got=%b want=1", d, req_ready[d]);
        else n_pass++;
        drive(d, rw, sz, sg, a, wd);
        @(posedge clk); @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1;
        while (resp_valid[d] !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        n_total++;
        if (resp_valid[d] !== 1'b1 || n != lat)
            $display("FAIL latency d=%0d addr=%h got=%0d want=%0d", d, a, n, lat);
        else n_pass++;
        q = sbq.pop_front();
        n_total++;
        if (resp_rdata[d] !== q.rdata)
            $display("FAIL rdata d=%0d addr=%h got=%h want=%h", d, a, resp_rdata[d], q.rdata);
        else n_pass++;
        n_total++;
        if (resp_err[d] !== q.err)
            $display("FAIL err d=%0d addr=%h got=%b want=%b", d, a, resp_err[d], q.err);
        else n_pass++;
        got     = resp_rdata[d];
        got_err = resp_err[d];
        resp_ready[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready[d] = 1'b0;
        n_total++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1)
            $display("FAIL release d=%0d got valid=%b ready=%b want valid=0 ready=1",
                     d, resp_valid[d], req_ready[d]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 2'b00; req_valid = '0; req_rw = '0; req_signed = '0; resp_ready = '0;
        req_size = '0; req_addr = '0; req_wdata = '0;
        #12;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0)
                $display("FAIL reset_state d=%0d got rdy=%b v=%b rd=%h e=%b want 1/0/0/0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 2'b11;
        @(negedge clk);
    endtask

    task automatic test_word_byte();
        logic [31:0] got;
        logic        ge;
        logic [7:0]  exp_b [4];
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        txn(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, got, ge);
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0, got, ge);
        n_total++;
        if (got !== 32'hDEAD_BEEF) $display("FAIL word_load got=%h want=deadbeef", got);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            txn(0, 0, 2'b00, 0, 32'h10 + i, 32'h0, got, ge);
            n_total++;
            if (got !== {24'd0, exp_b[i]}) $display("FAIL byte_load[%0d] got=%h want=%h", i, got, exp_b[i]);
            else n_pass++;
        end
    endtask

    task automatic test_sign_ext();
        logic [31:0] got;
        logic        ge;
        txn(0, 0, 2'b00, 1, 32'h13, 32'h0, got, ge);
        n_total++;
        if (got !== 32'hFFFF_FFEF) $display("FAIL byte_signed got=%h want=ffffffef", got);
        else n_pass++;
        txn(0, 0, 2'b00, 0, 32'h13, 32'h0, got, ge);
        n_total++;
        if (got !== 32'h0000_00EF) $display("FAIL byte_unsigned got=%h want=000000ef", got);
        else n_pass++;
        txn(0, 0, 2'b01, 1, 32'h12, 32'h0, got, ge);
        n_total++;
        if (got !== 32'hFFFF_BEEF) $display("FAIL half_signed got=%h want=ffffbeef", got);
        else n_pass++;
        txn(0, 0, 2'b01, 0, 32'h10, 32'h0, got, ge);
        n_total++;
        if (got !== 32'h0000_DEAD) $display("FAIL half_unsigned got=%h want=0000dead", got);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] got;
        logic        ge;
        txn(0, 1, 2'b10, 0, 32'h20, 32'h0102_0304, got, ge);
        txn(0, 1, 2'b10, 0, 32'h21, 32'hFFFF_FFFF, got, ge);
        n_total++;
        if (ge !== 1'b1) $display("FAIL misaligned_word got=%b want=1", ge);
        else n_pass++;
        txn(0, 1, 2'b01, 0, 32'h23, 32'hFFFF_FFFF, got, ge);
        n_total++;
        if (ge !== 1'b1) $display("FAIL misaligned_half got=%b want=1", ge);
        else n_pass++;
        txn(0, 0, 2'b10, 0, 32'h20, 32'h0, got, ge);
        n_total++;
        if (got !== 32'h0102_0304) $display("FAIL unchanged_after_err got=%h want=01020304", got);
        else n_pass++;
        txn(0, 1, 2'b11, 0, 32'h20, 32'hFFFF_FFFF, got, ge);
        n_total++;
        if (ge !== 1'b1) $display("FAIL reserved_size got=%b want=1", ge);
        else n_pass++;
    endtask

    task automatic test_bounds();
        logic [31:0] got;
        logic        ge;
        txn(0, 0, 2'b10, 0, 32'hFD, 32'h0, got, ge);
        n_total++;
        if (ge !== 1'b1) $display("FAIL word_0xfd got=%b want=1", ge);
        else n_pass++;
        txn(0, 0, 2'b10, 0, 32'h100, 32'h0, got, ge);
        n_total++;
        if (ge !== 1'b1) $display("FAIL word_0x100 got=%b want=1", ge);
        else n_pass++;
        txn(0, 1, 2'b00, 0, 32'hFF, 32'h0000_005A, got, ge);
        n_total++;
        if (ge !== 1'b0) $display("FAIL byte_store_0xff got=%b want=0", ge);
        else n_pass++;
        txn(0, 0, 2'b00, 0, 32'hFF, 32'h0, got, ge);
        n_total++;
        if (got !== 32'h0000_005A) $display("FAIL byte_load_0xff got=%h want=0000005a", got);
        else n_pass++;
        txn(0, 0, 2'b01, 0, 32'hFFFF_FFFE, 32'h0, got, ge);
        n_total++;
        if (ge !== 1'b1) $display("FAIL high_addr got=%b want=1", ge);
        else n_pass++;
    endtask

    task automatic test_wait_hold();
        logic [31:0] got;
        logic        ge;
        exp_t        e;
        exp_t        q;
        int          n;
        model(1, 1, 2'b10, 0, 32'h50, 32'h1122_3344, e.rdata, e.err);
        sbq.push_back(e);
        drive(1, 1, 2'b10, 0, 32'h50, 32'h1122_3344);
        @(posedge clk); @(negedge clk);
        req_valid[1] = 1'b0;
        n = 1;
        while (resp_valid[1] !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        n_total++;
        if (n != 4) $display("FAIL hold_latency got=%0d want=4", n);
        else n_pass++;
        q = sbq.pop_front();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) drive(1, 1, 2'b10, 0, 32'h50, 32'h5566_7788);
            @(posedge clk); @(negedge clk);
            n_total++;
            if (resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0 ||
                resp_rdata[1] !== q.rdata || resp_err[1] !== q.err)
                $display("FAIL hold[%0d] got v=%b rdy=%b rd=%h e=%b want 1/0/%h/%b",
                         c, resp_valid[1], req_ready[1], resp_rdata[1], resp_err[1], q.rdata, q.err);
            else n_pass++;
        end
        req_valid[1]  = 1'b0;
        resp_ready[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready[1] = 1'b0;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
            $display("FAIL ignored_req got v=%b rdy=%b want v=0 rdy=1", resp_valid[1], req_ready[1]);
        else n_pass++;
        txn(1, 0, 2'b10, 0, 32'h50, 32'h0, got, ge);
        n_total++;
        if (got !== 32'h1122_3344) $display("FAIL hold_commit got=%h want=11223344", got);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] got;
        logic        ge;
        txn(1, 1, 2'b10, 0, 32'h40, 32'hA5A5_A5A5, got, ge);
        drive(1, 1, 2'b10, 0, 32'h40, 32'h1234_5678);
        @(posedge clk); @(negedge clk);
        req_valid[1] = 1'b0;
        rst_n[1] = 1'b0;
        #1;
        n_total++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 ||
            resp_rdata[1] !== 32'd0 || resp_err[1] !== 1'b0)
            $display("FAIL reset_in_wait got rdy=%b v=%b rd=%h e=%b want 1/0/0/0",
                     req_ready[1], resp_valid[1], resp_rdata[1], resp_err[1]);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        txn(1, 0, 2'b10, 0, 32'h40, 32'h0, got, ge);
        n_total++;
        if (got !== 32'hA5A5_A5A5) $display("FAIL discarded_store got=%h want=a5a5a5a5", got);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_sign_ext();
        test_errors();
        test_bounds();
        test_wait_hold();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
